// File: rtl/instruction_fetch_pkg.sv
// Shared processor definitions for the instruction-fetch unit:
// FSM state encoding, reset PC default and the word-alignment constant.
package instruction_fetch_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DELIVER = 3'd1,
    ST_RESOLVE = 3'd2,
    ST_HALTED  = 3'd3,
    ST_FAULT   = 3'd4
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [1:0]  WORD_ALIGN       = 2'b00;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == WORD_ALIGN;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read bus: the fetch unit is master, the memory is slave.
interface instruction_fetch_if;

  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/fetch_timeout_counter.sv
// Counts FETCH cycles spent waiting for imem_ack and flags the last permitted cycle.
module fetch_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic at_limit
);

  localparam int            W     = $clog2(TIMEOUT) + 1;
  localparam logic [W-1:0]  LIMIT = W'(TIMEOUT - 1);

  logic [W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (tick) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign at_limit = (count_q == LIMIT);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction-fetch unit: fetches one word, hands it to decode, then waits for
// the branch unit to resolve the next PC before fetching again.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                reset,
  instruction_fetch_if.master imem,
  output logic [31:0]         instr_out,
  output logic [31:0]         pc_out,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic [31:0]         pc_next,
  input  logic                pc_next_valid,
  input  logic                halt,
  output logic                halted,
  output logic                fault,
  output logic [31:0]         instr_count
);

  fetch_state_e state_q, state_d;
  logic         run_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  count_q;
  logic         fetch_active;
  logic         wait_at_limit;
  logic         pc_next_ok;

  // run_q holds off the first request until one clock edge after reset release.
  assign fetch_active = run_q && (state_q == ST_FETCH);
  assign pc_next_ok   = is_word_aligned(pc_next);

  fetch_timeout_counter #(
    .TIMEOUT (IMEM_TIMEOUT)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clear    (!fetch_active),
    .tick     (fetch_active && !imem.ack),
    .at_limit (wait_at_limit)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      run_q   <= 1'b0;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (fetch_active && imem.ack) begin
        instr_q <= imem.rdata;
      end
      if (state_q == ST_DELIVER && instr_ready) begin
        count_q <= count_q + 32'd1;
      end
      if (state_q == ST_RESOLVE && pc_next_valid && pc_next_ok) begin
        pc_q <= pc_next;
      end
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH: begin
        if (fetch_active) begin
          if (imem.ack) begin
            state_d = ST_DELIVER;
          end else if (wait_at_limit) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_DELIVER: begin
        if (instr_ready) begin
          state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        if (pc_next_valid) begin
          if (!pc_next_ok) begin
            state_d = ST_FAULT;
          end else if (halt) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_FAULT;
    endcase
  end

  assign imem.req    = fetch_active;
  assign imem.addr   = pc_q;
  assign pc_out      = pc_q;
  assign instr_out   = instr_q;
  assign instr_count = count_q;
  assign instr_valid = (state_q == ST_DELIVER);
  assign halted      = (state_q == ST_HALTED);
  assign fault       = (state_q == ST_FAULT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with hand-computed expectations.
module tb_instruction_fetch;

  logic        clock;
  logic        reset;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_next;
  logic        pc_next_valid;
  logic        halt;
  logic        halted;
  logic        fault;
  logic [31:0] instr_count;

  int n_compared;
  int n_mismatched;

  instruction_fetch_if imem ();

  instruction_fetch #(
    .RESET_PC     (32'h0000_0000),
    .IMEM_TIMEOUT (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .imem          (imem),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .pc_next       (pc_next),
    .pc_next_valid (pc_next_valid),
    .halt          (halt),
    .halted        (halted),
    .fault         (fault),
    .instr_count   (instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves the DUT in FETCH cycle 1 (request active, wait counter 0).
  task automatic reset_pulse();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    n_compared    = 0;
    n_mismatched  = 0;
    reset         = 1'b0;
    instr_ready   = 1'b0;
    pc_next       = '0;
    pc_next_valid = 1'b0;
    halt          = 1'b0;
    imem.ack      = 1'b0;
    imem.rdata    = '0;

    // Reset state
    tick();
    tick();
    check("rst_req",    {31'd0, imem.req},    32'd0);
    check("rst_pc",     pc_out,               32'h0);
    check("rst_instr",  instr_out,            32'h0);
    check("rst_count",  instr_count,          32'd0);
    check("rst_valid",  {31'd0, instr_valid}, 32'd0);
    check("rst_halted", {31'd0, halted},      32'd0);
    check("rst_fault",  {31'd0, fault},       32'd0);
    reset = 1'b1;
    #1;
    check("rel_req_before_edge", {31'd0, imem.req}, 32'd0);

    // First fetch, ack after two waiting cycles
    tick();
    check("f0_req",  {31'd0, imem.req}, 32'd1);
    check("f0_addr", imem.addr,         32'h0);
    tick();
    check("f0_req_c2", {31'd0, imem.req}, 32'd1);
    imem.ack   = 1'b1;
    imem.rdata = 32'h1234_5678;
    #1;
    check("f0_valid_with_ack", {31'd0, instr_valid}, 32'd0);
    tick();
    imem.ack = 1'b0;
    check("d0_valid", {31'd0, instr_valid}, 32'd1);
    check("d0_instr", instr_out,            32'h1234_5678);
    check("d0_req",   {31'd0, imem.req},    32'd0);

    // Stalled delivery; stray ack and pc_next_valid must be ignored
    imem.ack      = 1'b1;
    imem.rdata    = 32'hFFFF_0000;
    pc_next       = 32'h0000_0003;
    pc_next_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_instr", instr_out,            32'h1234_5678);
      check("stall_pc",    pc_out,               32'h0);
      check("stall_count", instr_count,          32'd0);
    end
    imem.ack      = 1'b0;
    pc_next_valid = 1'b0;
    check("stall_no_fault", {31'd0, fault}, 32'd0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("acc_count", instr_count,          32'd1);
    check("acc_valid", {31'd0, instr_valid}, 32'd0);
    check("acc_req",   {31'd0, imem.req},    32'd0);

    // Resolve waits for pc_next_valid, then redirects to 0x40
    tick();
    check("res_wait_req", {31'd0, imem.req}, 32'd0);
    pc_next       = 32'h0000_0040;
    pc_next_valid = 1'b1;
    tick();
    pc_next_valid = 1'b0;
    check("br_req",  {31'd0, imem.req}, 32'd1);
    check("br_addr", imem.addr,         32'h40);
    check("br_pc",   pc_out,            32'h40);

    // Second instruction then a misaligned pc_next
    imem.ack   = 1'b1;
    imem.rdata = 32'hDEAD_BEEF;
    tick();
    imem.ack = 1'b0;
    check("d1_instr", instr_out, 32'hDEAD_BEEF);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("d1_count", instr_count, 32'd2);
    pc_next       = 32'h0000_0042;
    pc_next_valid = 1'b1;
    tick();
    pc_next_valid = 1'b0;
    check("mis_fault", {31'd0, fault},    32'd1);
    check("mis_req",   {31'd0, imem.req}, 32'd0);
    check("mis_pc",    pc_out,            32'h40);
    imem.ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mis_fault_sticky", {31'd0, fault},    32'd1);
      check("mis_req_low",      {31'd0, imem.req}, 32'd0);
    end
    imem.ack = 1'b0;

    // imem timeout: 16 cycles with no ack
    reset_pulse();
    check("to_req_c1", {31'd0, imem.req}, 32'd1);
    check("to_clr",    {31'd0, fault},    32'd0);
    for (int i = 2; i <= 16; i++) begin
      tick();
      check("to_waiting", {31'd0, fault},    32'd0);
      check("to_req",     {31'd0, imem.req}, 32'd1);
    end
    tick();
    check("to_fault",     {31'd0, fault},    32'd1);
    check("to_req_low",   {31'd0, imem.req}, 32'd0);
    imem.ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_fault_sticky", {31'd0, fault},       32'd1);
      check("to_no_valid",     {31'd0, instr_valid}, 32'd0);
    end
    imem.ack = 1'b0;

    // Halt in RESOLVE
    reset_pulse();
    imem.ack   = 1'b1;
    imem.rdata = 32'h0000_0013;
    tick();
    imem.ack    = 1'b0;
    instr_ready = 1'b1;
    tick();
    instr_ready   = 1'b0;
    halt          = 1'b1;
    pc_next       = 32'h0000_0100;
    pc_next_valid = 1'b1;
    tick();
    halt          = 1'b0;
    pc_next_valid = 1'b0;
    check("halt_halted", {31'd0, halted},   32'd1);
    check("halt_pc",     pc_out,            32'h100);
    check("halt_fault",  {31'd0, fault},    32'd0);
    check("halt_count",  instr_count,       32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("halt_req_low", {31'd0, imem.req}, 32'd0);
      check("halt_sticky",  {31'd0, halted},   32'd1);
    end

    // Reset during DELIVER of an instruction at 0x80
    reset_pulse();
    imem.ack   = 1'b1;
    imem.rdata = 32'hAAAA_5555;
    tick();
    imem.ack    = 1'b0;
    instr_ready = 1'b1;
    tick();
    instr_ready   = 1'b0;
    pc_next       = 32'h0000_0080;
    pc_next_valid = 1'b1;
    tick();
    pc_next_valid = 1'b0;
    imem.ack   = 1'b1;
    imem.rdata = 32'h5555_AAAA;
    tick();
    imem.ack = 1'b0;
    check("rd_pre_valid", {31'd0, instr_valid}, 32'd1);
    check("rd_pre_pc",    pc_out,               32'h80);
    reset = 1'b0;
    #1;
    check("rd_pc",    pc_out,               32'h0);
    check("rd_count", instr_count,          32'd0);
    check("rd_valid", {31'd0, instr_valid}, 32'd0);
    check("rd_instr", instr_out,            32'h0);
    imem.ack = 1'b1;
    tick();
    check("rd_late_ack", instr_out, 32'h0);
    reset    = 1'b1;
    imem.ack = 1'b0;
    tick();
    check("rd_restart_req",  {31'd0, imem.req},    32'd1);
    check("rd_restart_addr", imem.addr,            32'h0);
    tick();
    check("rd_restart_valid", {31'd0, instr_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of first fetch after reset.
REQ-002 Parameter IMEM_TIMEOUT, default 16, max cycles waiting for imem_ack before fault.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  word-aligned read address, equal to pc_out.
REQ-007 imem_ack  input  1  one-cycle read completion strobe.
REQ-008 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-009 instr_out  output  32  latched instruction to decode.
REQ-010 pc_out  output  32  current PC; feeds the branch unit pc_in.
REQ-011 instr_valid  output  1  instr_out holds an undelivered instruction.
REQ-012 instr_ready  input  1  decode accepts instr_out.
REQ-013 pc_next  input  32  resolved next PC from the branch unit.
REQ-014 pc_next_valid  input  1  pc_next is resolved for the delivered instruction.
REQ-015 halt  input  1  stop fetching after the current instruction resolves.
REQ-016 halted  output  1  unit is in HALTED.
REQ-017 fault  output  1  sticky: misaligned pc_next or imem timeout.
REQ-018 instr_count  output  32  number of instructions delivered since reset.

Function
REQ-019 FSM states: FETCH, DELIVER, RESOLVE, HALTED, FAULT; the only outputs asserted by state are imem_req (FETCH only), instr_valid (DELIVER only), halted (HALTED only), fault (FAULT only).
REQ-020 FETCH: imem_req=1 and imem_addr=pc_out every cycle; on imem_ack, instr_out<=imem_rdata and next state is DELIVER.
REQ-021 FETCH: wait counter increments each cycle without imem_ack; on reaching IMEM_TIMEOUT-1 without ack, next state is FAULT.
REQ-022 DELIVER: instr_out and pc_out stable; on instr_valid&&instr_ready, instr_count increments (wraps at 2^32-1 to 0) and next state is RESOLVE.
REQ-023 RESOLVE: on pc_next_valid with pc_next[1:0]=0, pc_out<=pc_next; next state is HALTED if halt=1 that cycle, else FETCH.
REQ-024 RESOLVE: on pc_next_valid with pc_next[1:0]!=0, pc_out is unchanged and next state is FAULT.
REQ-025 pc_next_valid outside RESOLVE and imem_ack outside FETCH are ignored.
REQ-026 halt is sampled only in RESOLVE; HALTED and FAULT are terminal until reset.
REQ-027 Latency: imem_ack to instr_valid is 1 cycle; pc_next_valid to imem_req is 1 cycle.
REQ-028 Wait counter clears on every FETCH entry; its width is clog2(IMEM_TIMEOUT)+1.

Reset
REQ-029 While reset=0: state=FETCH, pc_out=RESET_PC, instr_out=0, instr_count=0, wait counter=0, fault=halted=instr_valid=0.
REQ-030 imem_req is 0 while reset=0 and is 1 from the first rising clock edge after reset deasserts.
REQ-031 Reset asserted mid-fetch or mid-delivery discards the instruction; a late imem_ack is ignored.

Structure
REQ-032 FSM state encoding, RESET_PC default and the 2'b00 alignment constant are in the shared processor package.
REQ-033 The wait counter with timeout compare is a sub-module, fetch_timeout_counter; all other logic is in instruction_fetch.

Verification
REQ-034 Reset release, imem_ack after 2 cycles with rdata=32'h1234_5678 -> imem_addr=0, instr_valid 1 cycle after ack, instr_out=32'h1234_5678.
REQ-035 Deliver with instr_ready held 0 for 5 cycles -> instr_out and pc_out stable, instr_count stays 0; instr_ready=1 -> instr_count=1.
REQ-036 RESOLVE, pc_next=32'h0000_0040 -> next imem_addr=32'h40; pc_next=32'h0000_0042 -> fault=1, imem_req stays 0.
REQ-037 imem_ack withheld 16 cycles -> fault=1 after the 16th cycle; fault stays 1 until reset.
REQ-038 halt=1 with pc_next_valid in RESOLVE -> halted=1, pc_out=pc_next, imem_req never reasserts.
REQ-039 reset pulsed low during DELIVER -> pc_out=RESET_PC, instr_count=0, instr_valid=0 immediately, fetch restarts at RESET_PC.
